// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames bytes as start, data LSB-first, optional parity, stop bits,
// advancing one bit per baud tick, and owns the baud generator's run-enable and rate select.
module uart_tx_ctrl #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic [1:0]           baud_sel_req,
    output logic [1:0]           baud_sel,
    output logic                 baud_run,
    input  logic                 baud_tick,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
    localparam logic       LastStop = 1'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_en_q, parity_en_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [1:0]           baud_sel_q, baud_sel_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 baud_run_q, baud_run_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        parity_en_d  = parity_en_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        baud_sel_d   = baud_sel_q;
        frame_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                // Rate only follows the request between frames.
                baud_sel_d = baud_sel_req;
                if (tx_valid && tx_ready_q) begin
                    shift_d      = tx_data;
                    parity_bit_d = (^tx_data) ^ parity_odd;
                    parity_en_d  = parity_en;
                    state_d      = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    bit_cnt_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LastBit) begin
                        if (parity_en_q) begin
                            state_d = StParity;
                        end else begin
                            stop_cnt_d = 1'b0;
                            state_d    = StStop;
                        end
                    end
                end
            end
            StParity: begin
                if (baud_tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    if (stop_cnt_q == LastStop) begin
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are derived from the next state so they are registered alongside it.
    always_comb begin
        tx_d       = 1'b1;
        busy_d     = (state_d != StIdle);
        baud_run_d = (state_d != StIdle);
        tx_ready_d = (state_d == StIdle);
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            parity_en_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            stop_cnt_q   <= 1'b0;
            baud_sel_q   <= 2'b00;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            baud_run_q   <= 1'b0;
            tx_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            parity_en_q  <= parity_en_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            baud_sel_q   <= baud_sel_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            baud_run_q   <= baud_run_d;
            tx_ready_q   <= tx_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign baud_run   = baud_run_q;
    assign tx_ready   = tx_ready_q;
    assign frame_done = frame_done_q;
    assign baud_sel   = baud_sel_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frames are predicted as bit lists built from the framing rules
// and compared against tx once per cycle of every bit period.
module tb_uart_tx_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       parity_en;
    logic       parity_odd;
    logic [1:0] baud_sel_req;
    logic       baud_tick;

    logic       tx_ready1, baud_run1, tx1, busy1, frame_done1;
    logic [1:0] baud_sel1;
    logic       tx_ready2, baud_run2, tx2, busy2, frame_done2;
    logic [1:0] baud_sel2;

    logic       sel2 = 1'b0;
    logic       m_tx, m_busy, m_run, m_ready, m_fd;
    logic [1:0] m_sel;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready1), .parity_en(parity_en), .parity_odd(parity_odd),
        .baud_sel_req(baud_sel_req), .baud_sel(baud_sel1), .baud_run(baud_run1),
        .baud_tick(baud_tick), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
    );

    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready2), .parity_en(parity_en), .parity_odd(parity_odd),
        .baud_sel_req(baud_sel_req), .baud_sel(baud_sel2), .baud_run(baud_run2),
        .baud_tick(baud_tick), .tx(tx2), .busy(busy2), .frame_done(frame_done2)
    );

    assign m_tx    = sel2 ? tx2 : tx1;
    assign m_busy  = sel2 ? busy2 : busy1;
    assign m_run   = sel2 ? baud_run2 : baud_run1;
    assign m_ready = sel2 ? tx_ready2 : tx_ready1;
    assign m_fd    = sel2 ? frame_done2 : frame_done1;
    assign m_sel   = sel2 ? baud_sel2 : baud_sel1;

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Sends one frame on the selected DUT starting in the current cycle and checks it tick by
    // tick; returns in the cycle after the final stop tick.
    task automatic run_frame(input logic [7:0] data, input logic pen, input logic podd,
                             input int period, input logic stray, input logic hold,
                             input logic [7:0] next_data, input logic [1:0] mid_req,
                             input string name);
        bit         exp[$];
        bit         pbit;
        logic [1:0] lock_sel;
        int         errs;
        int         nstop;
        nstop = sel2 ? 2 : 1;
        exp = {};
        exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp.push_back(data[i]);
        pbit = (($countones(data) % 2) == 1) ^ podd;
        if (pen) exp.push_back(pbit);
        for (int s = 0; s < nstop; s++) exp.push_back(1'b1);

        tx_data    = data;
        parity_en  = pen;
        parity_odd = podd;
        tx_valid   = 1'b1;
        baud_tick  = stray;
        lock_sel   = baud_sel_req;
        n_tests++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_ready: got %b want 1", name, m_ready);
        end
        step();
        baud_tick = 1'b0;
        if (hold) begin
            tx_data = next_data;
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        n_tests++;
        if ({m_tx, m_busy, m_run, m_ready} !== 4'b0110) begin
            n_fail++;
            $display("FAIL %s start_entry: tx/busy/run/ready got %b want 0110",
                     name, {m_tx, m_busy, m_run, m_ready});
        end
        for (int b = 0; b < exp.size(); b++) begin
            errs = 0;
            for (int c = 0; c < period; c++) begin
                if (b == 2 && c == 0) baud_sel_req = mid_req;
                if (c == period - 1) baud_tick = 1'b1;
                if (m_tx !== exp[b]) errs++;
                if ({m_busy, m_run, m_ready, m_fd} !== 4'b1100) errs++;
                if (m_sel !== lock_sel) errs++;
                step();
                baud_tick = 1'b0;
            end
            n_tests++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL %s bit%0d: %0d bad cycles, want tx=%b busy=1 run=1 ready=0 sel=%b",
                         name, b, errs, exp[b], lock_sel);
            end
        end
        n_tests++;
        if ({m_tx, m_busy, m_run, m_ready, m_fd} !== 5'b10011) begin
            n_fail++;
            $display("FAIL %s frame_end: tx/busy/run/ready/done got %b want 10011",
                     name, {m_tx, m_busy, m_run, m_ready, m_fd});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if ({m_tx, m_busy, m_run, m_ready, m_fd, m_sel} !== 7'b1001000) begin
            n_fail++;
            $display("FAIL reset_init: got %b want 1001000", {m_tx, m_busy, m_run, m_ready, m_fd, m_sel});
        end
        reset = 1'b0;
        baud_sel_req = 2'b10;
        step();
        step();
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        // Start bit plus three data bits leaves the frame in data bit 3.
        for (int t = 0; t < 4; t++) begin
            step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
        end
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            n_tests++;
            if ({m_tx, m_busy, m_run, m_ready, m_fd, m_sel} !== 7'b1001000) begin
                n_fail++;
                $display("FAIL reset_mid%0d: got %b want 1001000", r,
                         {m_tx, m_busy, m_run, m_ready, m_fd, m_sel});
            end
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (m_sel !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_sel_resume: got %b want 10", m_sel);
        end
        for (int t = 0; t < 12; t++) begin
            baud_tick = (t % 3 == 0);
            step();
            n_tests++;
            if ({m_fd, m_busy, m_tx} !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_abandon%0d: done/busy/tx got %b want 001", t, {m_fd, m_busy, m_tx});
            end
        end
        baud_tick    = 1'b0;
        baud_sel_req = 2'b00;
        step();
    endtask

    task automatic test_8n1();
        run_frame(8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b0, 8'h00, baud_sel_req, "8n1_55");
        step();
        n_tests++;
        if (m_fd !== 1'b0) begin
            n_fail++;
            $display("FAIL 8n1_done_once: got %b want 0", m_fd);
        end
    endtask

    task automatic test_parity();
        run_frame(8'h07, 1'b1, 1'b0, 4, 1'b0, 1'b0, 8'h00, baud_sel_req, "par_even_07");
        run_frame(8'h07, 1'b1, 1'b1, 4, 1'b0, 1'b0, 8'h00, baud_sel_req, "par_odd_07");
    endtask

    task automatic test_stop2();
        sel2 = 1'b1;
        do_reset();
        run_frame(8'h07, 1'b1, 1'b1, 3, 1'b0, 1'b0, 8'h00, baud_sel_req, "8o2_07");
        run_frame(8'hC3, 1'b0, 1'b0, 5, 1'b0, 1'b0, 8'h00, baud_sel_req, "8n2_c3");
        sel2 = 1'b0;
        do_reset();
    endtask

    task automatic test_back_to_back();
        run_frame(8'hA1, 1'b0, 1'b0, 6, 1'b0, 1'b1, 8'h3C, baud_sel_req, "b2b_a1");
        run_frame(8'h3C, 1'b0, 1'b0, 6, 1'b0, 1'b0, 8'h00, baud_sel_req, "b2b_3c");
    endtask

    task automatic test_rate_lock();
        baud_sel_req = 2'b00;
        step();
        run_frame(8'h9E, 1'b0, 1'b0, 4, 1'b0, 1'b0, 8'h00, 2'b11, "rate_lock");
        n_tests++;
        if (m_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL rate_lock_done_cycle: got %b want 00", m_sel);
        end
        step();
        n_tests++;
        if (m_sel !== 2'b11) begin
            n_fail++;
            $display("FAIL rate_lock_after: got %b want 11", m_sel);
        end
        baud_sel_req = 2'b01;
        step();
        n_tests++;
        if (m_sel !== 2'b01) begin
            n_fail++;
            $display("FAIL rate_idle_follow: got %b want 01", m_sel);
        end
        baud_sel_req = 2'b00;
        step();
    endtask

    task automatic test_stray_ticks();
        for (int t = 0; t < 5; t++) begin
            baud_tick = 1'b1;
            step();
            n_tests++;
            if ({m_tx, m_busy, m_run, m_ready} !== 4'b1001) begin
                n_fail++;
                $display("FAIL stray_idle%0d: tx/busy/run/ready got %b want 1001",
                         t, {m_tx, m_busy, m_run, m_ready});
            end
        end
        run_frame(8'h6B, 1'b0, 1'b0, 5, 1'b1, 1'b0, 8'h00, baud_sel_req, "stray_accept");
        step();
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int k = 0; k < 8; k++) begin
            sel2 = 1'($urandom);
            do_reset();
            baud_sel_req = 2'($urandom);
            step();
            d = 8'($urandom);
            run_frame(d, 1'($urandom), 1'($urandom), 2 + int'($urandom_range(0, 5)), 1'($urandom),
                      1'b0, 8'h00, baud_sel_req, $sformatf("rand%0d", k));
        end
        sel2 = 1'b0;
        do_reset();
    endtask

    initial begin
        reset        = 1'b1;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        parity_en    = 1'b0;
        parity_odd   = 1'b0;
        baud_sel_req = 2'b00;
        baud_tick    = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_rate_lock();
        test_stray_ticks();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences the baud generator and the serial TX line. It accepts bytes over a valid/ready handshake and owns the generator's run-enable and rate select. It frames each byte as start, data LSB-first, optional parity and stop bits, advancing one bit per baud tick. It sits between the APB-UART register block (TX holding data, line-control fields) and the baud generator.

## Interface
- DATA_BITS, 8: data bits per frame; legal 5..8.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to send; sampled on accept.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  controller can accept; high only in IDLE.
- parity_en  in  1  append a parity bit; sampled on accept.
- parity_odd  in  1  1 = odd parity, 0 = even; sampled on accept.
- baud_sel_req  in  2  requested rate: 00=2400, 01=4800, 10=9600, 11=19200.
- baud_sel  out  2  rate select driven to the baud generator.
- baud_run  out  1  enable to the generator; generator holds its counter cleared while low.
- baud_tick  in  1  one-cycle pulse from the generator marking the end of a bit period.
- tx  out  1  serial output; idle high.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: tx=1, baud_run=0, busy=0, tx_ready=1. baud_sel <= baud_sel_req every IDLE cycle. The rate never changes mid-frame.
- Accept = tx_valid & tx_ready. On accept:
  - latch the shift register with tx_data;
  - latch parity_bit = ^tx_data ^ parity_odd;
  - latch parity_en;
  - go to START.
- START: tx=0. On baud_tick go to DATA with bit_cnt=0.
- DATA: tx=shift[0]. On each baud_tick, shift right and increment bit_cnt. On the tick where bit_cnt==DATA_BITS-1, go to PARITY if the latched parity_en is set, else go to STOP.
- PARITY: tx=parity_bit. On baud_tick go to STOP with stop_cnt=0.
- STOP: tx=1. On each baud_tick, increment stop_cnt. On the tick where stop_cnt==STOP_BITS-1, go to IDLE and pulse frame_done.
- busy=1 and baud_run=1 in every state except IDLE.
- baud_tick is ignored while in IDLE, including the accept cycle. Because baud_run=0 there, the first bit period is a full generator period.
- Changes to tx_data, parity_en or parity_odd after accept have no effect on the current frame.
- Frame length in ticks = 1 + DATA_BITS + parity_en + STOP_BITS. This is 10 for 8N1 and 12 for 8O2.
- Reset (any state, including mid-frame) drives next cycle:
  - state=IDLE, tx=1, baud_run=0, busy=0, frame_done=0, tx_ready=1, baud_sel=2'b00;
  - counters and shift register cleared.
  - The partial frame is abandoned, with no frame_done.

## Timing
- Accept in cycle N → in cycle N+1: tx=0, busy=1, baud_run=1, tx_ready=0.
- Each state transition takes effect the cycle after the baud_tick that causes it.
- Final stop-bit tick in cycle M → in cycle M+1: tx=1, busy=0, baud_run=0, frame_done=1, tx_ready=1.
- Back-to-back frames: an accept in cycle M+1 gives tx=0 in M+2. The inter-frame gap is one clock plus the generator restart period.
- baud_sel updates one cycle after baud_sel_req changes while in IDLE. A request made mid-frame takes effect in the first IDLE cycle after the frame.
- tx_valid held without tx_ready causes no side effects. Data is not required to stay stable after accept.

## Test plan
- Reset: assert reset for 2 cycles mid-frame (DATA, bit 3) → next cycle tx=1, busy=0, baud_run=0, tx_ready=1, baud_sel=00; no frame_done.
- 8N1, tx_data=0x55, tick every 16 clocks → tx sequence, one value per tick period: 0,1,0,1,0,1,0,1,0,1. frame_done fires exactly once, 1 cycle after the 10th tick.
- Parity: 0x07 with even parity → parity bit 1; 0x07 with odd parity → parity bit 0. STOP_BITS=2 → 12 ticks per frame, tx high for the last 2.
- Handshake: tx_valid=1 continuously with bytes 0xA1, 0x3C → tx_ready is high for exactly 1 cycle between frames; both frames are correct; the second start bit begins 1 cycle after frame_done.
- Rate lock: baud_sel_req changes 00→11 mid-frame → baud_sel stays 00 until the cycle after frame_done, then becomes 11.
- Stray ticks: baud_tick pulses while IDLE and in the accept cycle → no state change; the frame still lasts exactly 10 ticks after baud_run rises.
